axi_lite_matmul_responder: RTL

AXI4-Lite responder that answers the master-side register writes and reads issued by the system's AXI4-Lite master BFM. It holds a 2x2 signed 16-bit matrix pair A and B and computes C = A x B with one shared multiplier over 8 cycles. It exposes the 32-bit C elements and a control/status register through the same slave port. It sits behind the interconnect as the S00_AXI target of the multiplication IP.

---
 rtl/axi_lite_matmul_pkg.sv | 52 +++++
 rtl/matmul_mac_engine.sv | 89 ++++++++
 rtl/axi_lite_matmul_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/axi_lite_matmul_pkg.sv
// Shared register map, CTRL bit positions, operand/result types and FSM encoding
// for the AXI4-Lite 2x2 matrix-multiply responder.
package axi_lite_matmul_pkg;

  localparam int OPND_W = 16;
  localparam int RES_W  = 32;

  localparam logic [5:0] ADDR_A_ROW0 = 6'h00;
  localparam logic [5:0] ADDR_A_ROW1 = 6'h04;
  localparam logic [5:0] ADDR_B_ROW0 = 6'h08;
  localparam logic [5:0] ADDR_B_ROW1 = 6'h0C;
  localparam logic [5:0] ADDR_CTRL   = 6'h10;
  localparam logic [5:0] ADDR_C00    = 6'h14;
  localparam logic [5:0] ADDR_C01    = 6'h18;
  localparam logic [5:0] ADDR_C10    = 6'h1C;
  localparam logic [5:0] ADDR_C11    = 6'h20;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_BUSY  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } mac_state_e;

  typedef logic signed [OPND_W-1:0] opnd_t;
  typedef logic signed [RES_W-1:0]  res_t;

  // Packed so that {ROW1, ROW0} of the register map overlays the struct directly.
  typedef struct packed {
    opnd_t m11;
    opnd_t m10;
    opnd_t m01;
    opnd_t m00;
  } mat2_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/matmul_mac_engine.sv
// 2x2 signed matrix multiply on one shared 16x16 multiplier: 8 CALC cycles, then a
// one-cycle FINISH with done_pulse_o; start_i is only honoured from IDLE or FINISH.
module matmul_mac_engine
  import axi_lite_matmul_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  start_i,
  input  mat2_t a_i,
  input  mat2_t b_i,
  output logic  busy_o,
  output logic  done_pulse_o,
  output res_t  c00_o,
  output res_t  c01_o,
  output res_t  c10_o,
  output res_t  c11_o
);

  mac_state_e state_q, state_d;
  logic [2:0] step_q, step_d;
  res_t acc_q;
  logic [3:0][RES_W-1:0] c_q;

  logic [63:0] a_vec, b_vec;
  logic [1:0]  a_idx, b_idx;
  opnd_t       a_op, b_op;
  res_t        a_ext, b_ext, prod;

  // step = {i, j, l}: A(i,l) sits at index 2i+l, B(l,j) at index 2l+j.
  assign a_idx = {step_q[2], step_q[0]};
  assign b_idx = {step_q[0], step_q[1]};
  assign a_vec = a_i;
  assign b_vec = b_i;
  assign a_op  = a_vec[16*a_idx +: 16];
  assign b_op  = b_vec[16*b_idx +: 16];
  assign a_ext = {{(RES_W-OPND_W){a_op[OPND_W-1]}}, a_op};
  assign b_ext = {{(RES_W-OPND_W){b_op[OPND_W-1]}}, b_op};
  assign prod  = a_ext * b_ext;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CALC;
          step_d  = '0;
        end
      end
      ST_CALC: begin
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (start_i) begin
          state_d = ST_CALC;
          step_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (state_q == ST_CALC) begin
        if (!step_q[0]) acc_q <= prod;
        else            c_q[step_q[2:1]] <= acc_q + prod;
      end
    end
  end

  assign busy_o       = (state_q == ST_CALC);
  assign done_pulse_o = (state_q == ST_FINISH);
  assign c00_o        = c_q[0];
  assign c01_o        = c_q[1];
  assign c10_o        = c_q[2];
  assign c11_o        = c_q[3];

endmodule

// File: rtl/axi_lite_matmul_responder.sv
// AXI4-Lite slave for the matmul engine: single-beat write/read, one cycle from handshake to B/RVALID;
// AW+W accepted only together and never while BVALID is pending, AR never while RVALID is pending.
module axi_lite_matmul_responder
  import axi_lite_matmul_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            done_irq
);

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0] rdata_q, rd_mux;
  mat2_t       a_q, b_q;
  logic        done_q;
  logic        busy, done_pulse, wr_hs, rd_hs, start_apply, ab_wr_ok;
  logic [3:0]  wr_word, rd_word;
  res_t        c00, c01, c10, c11;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_word     = S_AXI_AWADDR[5:2];
  assign rd_word     = S_AXI_ARADDR[5:2];
  assign wr_hs       = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs       = arready_q & S_AXI_ARVALID;
  assign ab_wr_ok    = wr_hs & ~busy;
  assign start_apply = ab_wr_ok && (wr_word == ADDR_CTRL[5:2]) &&
                       S_AXI_WSTRB[CTRL_START] && S_AXI_WDATA[CTRL_START];

  matmul_mac_engine u_engine (
    .clk_i        (ACLK),
    .rst_ni       (ARESETN),
    .start_i      (start_apply),
    .a_i          (a_q),
    .b_i          (b_q),
    .busy_o       (busy),
    .done_pulse_o (done_pulse),
    .c00_o        (c00),
    .c01_o        (c01),
    .c10_o        (c10),
    .c11_o        (c11)
  );

  always_comb begin
    rd_mux = '0;
    case (rd_word)
      ADDR_A_ROW0[5:2]: rd_mux = a_q[31:0];
      ADDR_A_ROW1[5:2]: rd_mux = a_q[63:32];
      ADDR_B_ROW0[5:2]: rd_mux = b_q[31:0];
      ADDR_B_ROW1[5:2]: rd_mux = b_q[63:32];
      ADDR_CTRL[5:2]: begin
        // DONE is already visible in the FINISH cycle, before done_q catches up.
        rd_mux[CTRL_DONE] = done_q | done_pulse;
        rd_mux[CTRL_BUSY] = busy;
      end
      ADDR_C00[5:2]: rd_mux = c00;
      ADDR_C01[5:2]: rd_mux = c01;
      ADDR_C10[5:2]: rd_mux = c10;
      ADDR_C11[5:2]: rd_mux = c11;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      else if (wr_hs)               bvalid_q <= 1'b1;
      if (ab_wr_ok) begin
        if (wr_word == ADDR_A_ROW0[5:2]) a_q[31:0]  <= strb_merge(a_q[31:0],  S_AXI_WDATA, S_AXI_WSTRB);
        if (wr_word == ADDR_A_ROW1[5:2]) a_q[63:32] <= strb_merge(a_q[63:32], S_AXI_WDATA, S_AXI_WSTRB);
        if (wr_word == ADDR_B_ROW0[5:2]) b_q[31:0]  <= strb_merge(b_q[31:0],  S_AXI_WDATA, S_AXI_WSTRB);
        if (wr_word == ADDR_B_ROW1[5:2]) b_q[63:32] <= strb_merge(b_q[63:32], S_AXI_WDATA, S_AXI_WSTRB);
      end
      if (start_apply)     done_q <= 1'b0;
      else if (done_pulse) done_q <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign done_irq      = done_pulse;

endmodule
